// File: rtl/mm2s_pkg.sv
// -----------------------------------------------------------------------------
// mm2s_pkg
// Shared types and constants for the MM2S read-request scheduler.
//   state_e         : request FSM states
//   bytes_per_beat  : byte width of one data beat for a given data width
//   PAGE_BYTES      : 4 KB page size, the address window a burst must not cross
//                     when MM2S_4K_BOUNDARY_EN is defined
//   BURST_W         : width of a burst length in beats (1..256)
// -----------------------------------------------------------------------------
package mm2s_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CALC        = 3'd1,
    WAIT_CREDIT = 3'd2,
    ADDR        = 3'd3,
    DRAIN       = 3'd4
  } state_e;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_OFS_W = 12;
  localparam int unsigned BURST_W    = 9;

  localparam logic [BURST_W-1:0] BURST_ONE = 9'd1;

  // Number of bytes carried by one beat of the read data bus.
  function automatic int unsigned bytes_per_beat(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mm2s_burst_calc.sv
// -----------------------------------------------------------------------------
// mm2s_burst_calc
// Combinational burst sizing: the next burst is the smallest of the beats still
// to request, MAX_BURST and (when MM2S_4K_BOUNDARY_EN is defined) the beats
// left before the next 4 KB page boundary.
//
// Configuration macro: MM2S_4K_BOUNDARY_EN (undefined = no page limit)
//
// Ports:
//   remaining  in  LEN_W       beats of the command not yet requested (> 0)
//   page_ofs   in  12          byte offset of the next burst within its page
//   burst      out BURST_W     beats in the next burst
// -----------------------------------------------------------------------------
module mm2s_burst_calc
  import mm2s_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16,
  parameter int BEAT_SH   = 3
) (
  input  logic [LEN_W-1:0]      remaining,
  input  logic [PAGE_OFS_W-1:0] page_ofs,
  output logic [BURST_W-1:0]    burst
);

  localparam logic [LEN_W-1:0] MAX_BURST_L = LEN_W'(MAX_BURST);

  logic [LEN_W-1:0] len_lim_s;
  logic [LEN_W-1:0] burst_full_s;

  // Limit by beats still owed and by the largest legal burst.
  always_comb begin
    if (remaining < MAX_BURST_L) begin
      len_lim_s = remaining;
    end else begin
      len_lim_s = MAX_BURST_L;
    end
  end

`ifdef MM2S_4K_BOUNDARY_EN
  logic [PAGE_OFS_W:0] page_room_bytes_s;
  logic [PAGE_OFS_W:0] page_room_beats_s;
  logic [LEN_W-1:0]    page_room_l_s;

  // The start address is beat aligned, so the room is always at least one beat.
  assign page_room_bytes_s = (PAGE_OFS_W+1)'(PAGE_BYTES) - {1'b0, page_ofs};
  assign page_room_beats_s = page_room_bytes_s >> BEAT_SH;
  assign page_room_l_s     = LEN_W'(page_room_beats_s);

  // Also stop the burst at the end of the current 4 KB page.
  always_comb begin
    if (page_room_l_s < len_lim_s) begin
      burst_full_s = page_room_l_s;
    end else begin
      burst_full_s = len_lim_s;
    end
  end
`else
  logic unused_page_ofs_s;

  // Without the page limit the offset carries no information for sizing.
  assign unused_page_ofs_s = ^{page_ofs, 32'(BEAT_SH)};

  // Burst is limited only by remaining beats and MAX_BURST.
  always_comb begin
    burst_full_s = len_lim_s;
  end
`endif

  // The result never exceeds MAX_BURST (<= 256), so it fits BURST_W.
  assign burst = BURST_W'(burst_full_s);

endmodule

// File: rtl/mm2s_rd_ctrl.sv
// -----------------------------------------------------------------------------
// mm2s_rd_ctrl
// MM2S read-request scheduler. Splits one command (start address, length in
// beats) into read bursts on the AR channel and only issues a burst when the
// data FIFO has room for every beat that could still arrive.
//
// Configuration macro: MM2S_4K_BOUNDARY_EN (bursts do not cross 4 KB pages)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_addr, cmd_beats command payload
//   ar_valid/ready    read address handshake; ar_addr, ar_len (beats - 1)
//   r_beat, r_err     one beat pushed into the FIFO, with error response flag
//   fifo_level        current FIFO occupancy
//   busy              command in progress
//   done              one-cycle pulse once every beat of the command arrived
//   error             sticky error flag, cleared on the next command accept
// -----------------------------------------------------------------------------
module mm2s_rd_ctrl
  import mm2s_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [LEN_W-1:0]                 cmd_beats,
  output logic                             ar_valid,
  input  logic                             ar_ready,
  output logic [ADDR_W-1:0]                ar_addr,
  output logic [7:0]                       ar_len,
  input  logic                             r_beat,
  input  logic                             r_err,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH+1);
  localparam int FREE_W = LVL_W + 1;
  localparam int OUT_W  = LVL_W + 1;
  localparam int BPB_SH = $clog2(bytes_per_beat(DATA_W));

  localparam logic [FREE_W:0]  DEPTH_U = (FREE_W+1)'(FIFO_DEPTH);
  localparam logic [OUT_W-1:0] OUT_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  state_e              state_r;
  state_e              state_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [LEN_W-1:0]    remaining_r;
  logic [BURST_W-1:0]  burst_r;
  logic [BURST_W-1:0]  calc_burst_s;
  logic [OUT_W-1:0]    outstanding_r;
  logic [OUT_W-1:0]    out_inc_s;
  logic [OUT_W-1:0]    out_nxt_s;
  logic [FREE_W:0]     used_s;
  logic [FREE_W-1:0]   free_s;
  logic                credit_ok_s;
  logic                cmd_hs_s;
  logic                ar_hs_s;
  logic                last_burst_s;
  logic                beat_orphan_s;
  logic                err_set_s;
  logic                done_nxt_s;
  logic [ADDR_W-1:0]   burst_bytes_s;
  logic [7:0]          ar_len_nxt_s;

  logic                cmd_ready_r;
  logic                ar_valid_r;
  logic [ADDR_W-1:0]   ar_addr_r;
  logic [7:0]          ar_len_r;
  logic                busy_r;
  logic                done_r;
  logic                error_r;

  assign cmd_hs_s      = cmd_valid & cmd_ready_r;
  assign ar_hs_s       = ar_valid_r & ar_ready;
  assign last_burst_s  = (remaining_r == LEN_W'(burst_r));
  assign burst_bytes_s = ADDR_W'(burst_r) << BPB_SH;
  assign ar_len_nxt_s  = 8'(burst_r - BURST_ONE);

  mm2s_burst_calc #(
    .LEN_W     (LEN_W),
    .MAX_BURST (MAX_BURST),
    .BEAT_SH   (BPB_SH)
  ) u_burst_calc (
    .remaining (remaining_r),
    .page_ofs  (addr_r[PAGE_OFS_W-1:0]),
    .burst     (calc_burst_s)
  );

  // Free FIFO space counts beats already requested but not yet arrived.
  // The sum is one bit wider than the inputs so it cannot wrap.
  assign used_s = {2'b00, fifo_level} + {1'b0, outstanding_r};

  // Clamp free space at zero if occupancy plus in-flight ever exceeds depth.
  always_comb begin
    if (used_s >= DEPTH_U) begin
      free_s = {FREE_W{1'b0}};
    end else begin
      free_s = FREE_W'(DEPTH_U - used_s);
    end
  end

  assign credit_ok_s = ({{BURST_W{1'b0}}, free_s} >= {{FREE_W{1'b0}}, burst_r});

  // Next-state decode for the request FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_hs_s && (cmd_beats != {LEN_W{1'b0}})) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        state_nxt_s = WAIT_CREDIT;
      end
      WAIT_CREDIT: begin
        if (credit_ok_s) begin
          state_nxt_s = ADDR;
        end else begin
          state_nxt_s = WAIT_CREDIT;
        end
      end
      ADDR: begin
        if (ar_hs_s) begin
          if (last_burst_s) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = CALC;
          end
        end else begin
          state_nxt_s = ADDR;
        end
      end
      DRAIN: begin
        if (outstanding_r == {OUT_W{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // In-flight beat accounting; a beat with nothing outstanding is an orphan
  // and leaves the count untouched so it cannot wrap below zero.
  always_comb begin
    out_inc_s     = {OUT_W{1'b0}};
    out_nxt_s     = outstanding_r;
    beat_orphan_s = 1'b0;
    if (ar_hs_s) begin
      out_inc_s = OUT_W'(burst_r);
    end else begin
      out_inc_s = {OUT_W{1'b0}};
    end
    if (r_beat) begin
      if (outstanding_r == {OUT_W{1'b0}}) begin
        beat_orphan_s = 1'b1;
        out_nxt_s     = outstanding_r + out_inc_s;
      end else begin
        out_nxt_s     = outstanding_r + out_inc_s - OUT_ONE;
      end
    end else begin
      out_nxt_s = outstanding_r + out_inc_s;
    end
  end

  assign err_set_s  = r_beat & (r_err | beat_orphan_s);
  assign done_nxt_s = ((state_r == IDLE) && cmd_hs_s && (cmd_beats == {LEN_W{1'b0}})) ||
                      ((state_r == DRAIN) && (state_nxt_s == IDLE));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command datapath: running address, beats left to request, sized burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r      <= {ADDR_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
      burst_r     <= {BURST_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_hs_s) begin
            addr_r      <= cmd_addr;
            remaining_r <= cmd_beats;
          end
        end
        CALC: begin
          burst_r <= calc_burst_s;
        end
        ADDR: begin
          if (ar_hs_s) begin
            addr_r      <= addr_r + burst_bytes_s;
            remaining_r <= remaining_r - LEN_W'(burst_r);
          end
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

  // Outstanding beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_r <= {OUT_W{1'b0}};
    end else begin
      outstanding_r <= out_nxt_s;
    end
  end

  // Registered handshake and status outputs, decoded from the next state.
  // ar_addr/ar_len load only on entry to ADDR so they hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
      ar_valid_r  <= 1'b0;
      ar_addr_r   <= {ADDR_W{1'b0}};
      ar_len_r    <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cmd_ready_r <= (state_nxt_s == IDLE);
      ar_valid_r  <= (state_nxt_s == ADDR);
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= done_nxt_s;
      if ((state_r == WAIT_CREDIT) && (state_nxt_s == ADDR)) begin
        ar_addr_r <= addr_r;
        ar_len_r  <= ar_len_nxt_s;
      end
    end
  end

  // Sticky error: a set in the same cycle as a command accept wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_r <= 1'b0;
    end else if (err_set_s) begin
      error_r <= 1'b1;
    end else if (cmd_hs_s) begin
      error_r <= 1'b0;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign ar_valid  = ar_valid_r;
  assign ar_addr   = ar_addr_r;
  assign ar_len    = ar_len_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_mm2s_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mm2s_rd_ctrl
// Self-checking bench for mm2s_rd_ctrl. Expected AR bursts are pushed to a
// queue when a command is issued and compared against the bursts observed at
// AR handshakes. A simple memory model returns one beat per cycle for every
// accepted burst. Honours MM2S_4K_BOUNDARY_EN for the page-crossing case.
// -----------------------------------------------------------------------------
module tb_mm2s_rd_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_beat;
  logic        r_err;
  logic [4:0]  fifo_level;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int errors   = 0;
  int pending  = 0;
  int beat_no  = 0;
  int err_beat = -1;
  int done_cnt = 0;

  ar_t exp_q[$];
  ar_t obs_q[$];

  mm2s_rd_ctrl #(
    .ADDR_W(32), .LEN_W(16), .DATA_W(64), .FIFO_DEPTH(16), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .r_beat(r_beat), .r_err(r_err), .fifo_level(fifo_level),
    .busy(busy), .done(done), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ar_t mk(input logic [31:0] a, input logic [7:0] l);
    ar_t t;
    t.addr = a;
    t.len  = l;
    return t;
  endfunction

  // One clock: memory model drives r_beat, AR handshakes are recorded, then
  // outputs are sampled 1 time unit after the edge.
  task automatic step();
    r_beat = 1'b0;
    r_err  = 1'b0;
    if (pending > 0) begin
      r_beat  = 1'b1;
      pending = pending - 1;
      beat_no = beat_no + 1;
      r_err   = (beat_no == err_beat);
    end
    if (ar_valid === 1'b1 && ar_ready === 1'b1) begin
      obs_q.push_back(mk(ar_addr, ar_len));
      pending = pending + int'(ar_len) + 1;
    end
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] n);
    cmd_addr  = a;
    cmd_beats = n;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_to_done(input int max_cycles, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_beats = 16'd0;
    ar_ready = 1'b0; r_beat = 1'b0; r_err = 1'b0; fifo_level = 5'd0;
    step();
    step();
    rst = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b expected 1", cmd_ready); end
    checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL reset_ar_valid got %b expected 0", ar_valid); end
    checks++; if (ar_addr !== 32'd0 || ar_len !== 8'd0) begin errors++; $display("FAIL reset_ar_fields got %h/%h expected 0/0", ar_addr, ar_len); end
    checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status got busy/done/error %b expected 000", {busy, done, error}); end
  endtask

  task automatic test_multi_burst();
    bit  ok;
    int  lat;
    int  b0;
    int  d0;
    ar_t e;
    ar_t o;
    ar_ready = 1'b1; fifo_level = 5'd0; b0 = beat_no;
    exp_q.push_back(mk(32'h0000_1000, 8'd15));
    exp_q.push_back(mk(32'h0000_1080, 8'd15));
    exp_q.push_back(mk(32'h0000_1100, 8'd7));
    send_cmd(32'h0000_1000, 16'd40);
    lat = 1;
    while (ar_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    checks++; if (lat != 3) begin errors++; $display("FAIL multi_latency got %0d cycles expected 3", lat); end
    run_to_done(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL multi_done_timeout got no done expected done"); end
    checks++; if (beat_no - b0 != 40) begin errors++; $display("FAIL multi_beats_at_done got %0d expected 40", beat_no - b0); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL multi_burst_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL multi_burst got %h/%0d expected %h/%0d", o.addr, o.len, e.addr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
    d0 = done_cnt;
    repeat (5) step();
    checks++; if (done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL multi_single_done got extra %0d busy %b expected 0 0", done_cnt - d0, busy); end
  endtask

  task automatic test_credit();
    bit  ok;
    int  hi;
    int  w;
    ar_t e;
    ar_t o;
    ar_ready = 1'b1; fifo_level = 5'd10; hi = 0;
    exp_q.push_back(mk(32'h0000_2000, 8'd15));
    send_cmd(32'h0000_2000, 16'd16);
    repeat (10) begin step(); if (ar_valid === 1'b1) hi++; end
    checks++; if (hi != 0) begin errors++; $display("FAIL credit_blocked got %0d ar_valid cycles expected 0", hi); end
    fifo_level = 5'd0; w = 0;
    while (ar_valid !== 1'b1 && w < 10) begin step(); w++; end
    checks++; if (ar_valid !== 1'b1 || ar_len !== 8'd15) begin errors++; $display("FAIL credit_release got valid %b len %0d expected 1 15", ar_valid, ar_len); end
    run_to_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL credit_done_timeout got no done expected done"); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL credit_burst_count got %0d expected 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL credit_burst got %h/%0d expected %h/%0d", o.addr, o.len, e.addr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_ar_stall();
    bit          ok;
    int          w;
    int          bad;
    logic [31:0] a;
    logic [7:0]  l;
    ar_t         e;
    ar_t         o;
    ar_ready = 1'b0; fifo_level = 5'd0; w = 0; bad = 0;
    exp_q.push_back(mk(32'h0000_3000, 8'd3));
    send_cmd(32'h0000_3000, 16'd4);
    while (ar_valid !== 1'b1 && w < 10) begin step(); w++; end
    a = ar_addr; l = ar_len;
    checks++; if (a !== 32'h0000_3000 || l !== 8'd3) begin errors++; $display("FAIL stall_first got %h/%0d expected 3000/3", a, l); end
    repeat (5) begin
      step();
      if (ar_valid !== 1'b1 || ar_addr !== a || ar_len !== l) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_stable got %0d unstable cycles expected 0", bad); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL stall_no_handshake got %0d expected 0", obs_q.size()); end
    ar_ready = 1'b1;
    run_to_done(100, ok);
    checks++; if (!ok || obs_q.size() != 1) begin errors++; $display("FAIL stall_handshakes got %0d done %b expected 1 1", obs_q.size(), ok); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_burst got %h/%0d expected %h/%0d", o.addr, o.len, e.addr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_4k_boundary();
    bit  ok;
    ar_t e;
    ar_t o;
    ar_ready = 1'b1; fifo_level = 5'd0;
`ifdef MM2S_4K_BOUNDARY_EN
    exp_q.push_back(mk(32'h0000_0FF0, 8'd1));
    exp_q.push_back(mk(32'h0000_1000, 8'd5));
`else
    exp_q.push_back(mk(32'h0000_0FF0, 8'd7));
`endif
    send_cmd(32'h0000_0FF0, 16'd8);
    run_to_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL page_done_timeout got no done expected done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL page_burst_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL page_burst got %h/%0d expected %h/%0d", o.addr, o.len, e.addr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_error();
    bit  ok;
    ar_t e;
    ar_t o;
    ar_ready = 1'b1; fifo_level = 5'd0;
    err_beat = beat_no + 3;
    exp_q.push_back(mk(32'h0000_4000, 8'd7));
    send_cmd(32'h0000_4000, 16'd8);
    run_to_done(100, ok);
    checks++; if (!ok || error !== 1'b1) begin errors++; $display("FAIL err_at_done got error %b done %b expected 1 1", error, ok); end
    repeat (3) step();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b expected 1", error); end
    err_beat = -1;
    exp_q.push_back(mk(32'h0000_5000, 8'd3));
    send_cmd(32'h0000_5000, 16'd4);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_clear_on_accept got %b expected 0", error); end
    run_to_done(100, ok);
    checks++; if (!ok || error !== 1'b0) begin errors++; $display("FAIL err_clean_run got error %b done %b expected 0 1", error, ok); end
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL err_burst_count got %0d expected 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL err_burst got %h/%0d expected %h/%0d", o.addr, o.len, e.addr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_zero_beats();
    int d0;
    int hi;
    ar_ready = 1'b1; d0 = done_cnt; hi = 0;
    send_cmd(32'h0000_6000, 16'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_done got done/busy/ready %b%b%b expected 101", done, busy, cmd_ready); end
    repeat (5) begin step(); if (ar_valid === 1'b1) hi++; end
    checks++; if (hi != 0 || done_cnt - d0 != 1) begin errors++; $display("FAIL zero_quiet got ar %0d done %0d expected 0 1", hi, done_cnt - d0); end
  endtask

  task automatic test_orphan_beat();
    bit  ok;
    ar_t e;
    ar_t o;
    ar_ready = 1'b1;
    pending = 1;
    step();
    checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL orphan_error got error %b busy %b expected 1 0", error, busy); end
    exp_q.push_back(mk(32'h0000_7000, 8'd3));
    send_cmd(32'h0000_7000, 16'd4);
    run_to_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL orphan_recover got no done expected done"); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL orphan_burst got %h/%0d expected %h/%0d", o.addr, o.len, e.addr, e.len); end
    end
    checks++; if (obs_q.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL orphan_burst_count got obs %0d exp %0d expected 0 0", obs_q.size(), exp_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int w;
    int hi;
    ar_ready = 1'b0; w = 0; hi = 0;
    send_cmd(32'h0000_8000, 16'd16);
    while (ar_valid !== 1'b1 && w < 10) begin step(); w++; end
    checks++; if (ar_valid !== 1'b1) begin errors++; $display("FAIL rstmid_reach_addr got %b expected 1", ar_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (ar_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_outputs got valid/busy/ready %b%b%b expected 001", ar_valid, busy, cmd_ready); end
    ar_ready = 1'b1;
    repeat (6) begin step(); if (ar_valid === 1'b1) hi++; end
    checks++; if (hi != 0 || obs_q.size() != 0) begin errors++; $display("FAIL rstmid_no_burst got %0d valid cycles %0d handshakes expected 0 0", hi, obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_multi_burst();
    test_credit();
    test_ar_stall();
    test_4k_boundary();
    test_error();
    test_zero_beats();
    test_orphan_beat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
